// File: rtl/mag_comparator_serial.sv
// Bit-serial MSB-first magnitude compare accumulator fed by a 1-bit comparator slice.
// Define MAG_CMP_EARLY_DONE_EN to finish on the first decisive bit pair.
module mag_comparator_serial #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          bit_valid,
    input  logic          g_in,
    input  logic          e_in,
    input  logic          l_in,
    output logic          busy,
    output logic          done,
    output logic          g,
    output logic          e,
    output logic          l,
    output logic          err,
    output logic [CW-1:0] count
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t        state_q, state_d;
    logic          g_q, g_d;
    logic          e_q, e_d;
    logic          l_q, l_d;
    logic          err_q, err_d;
    logic [CW-1:0] count_q, count_d;

    logic one_hot;
    logic last_bit;
    logic decisive;

    // Exactly one of the three bits set.
    assign one_hot  = (g_in ^ e_in ^ l_in) & ~(g_in & e_in & l_in);
    assign last_bit = (count_q == LAST);
    assign decisive = e_q & one_hot & (g_in | l_in);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        e_d     = e_q;
        l_d     = l_q;
        err_d   = err_q;
        count_d = count_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SCAN;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    err_d   = 1'b0;
                    count_d = '0;
                end
            end
            SCAN: begin
                if (start) begin
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    err_d   = 1'b0;
                    count_d = '0;
                end else if (bit_valid) begin
                    count_d = count_q + CW'(1);
                    if (!one_hot) begin
                        err_d = 1'b1;
                    end else if (e_q && g_in) begin
                        g_d = 1'b1;
                        e_d = 1'b0;
                    end else if (e_q && l_in) begin
                        l_d = 1'b1;
                        e_d = 1'b0;
                    end
                    if (last_bit) begin
                        state_d = DONE;
                    end
`ifdef MAG_CMP_EARLY_DONE_EN
                    if (decisive) begin
                        state_d = DONE;
                    end
`endif
                end
            end
            DONE: begin
                if (start) begin
                    state_d = SCAN;
                    g_d     = 1'b0;
                    e_d     = 1'b1;
                    l_d     = 1'b0;
                    err_d   = 1'b0;
                    count_d = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef MAG_CMP_EARLY_DONE_EN
    logic unused_decisive;
    assign unused_decisive = decisive;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            g_q     <= 1'b0;
            e_q     <= 1'b0;
            l_q     <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            e_q     <= e_d;
            l_q     <= l_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Status decodes only from state registers; no input reaches an output.
    assign busy  = (state_q == SCAN);
    assign done  = (state_q == DONE);
    assign g     = g_q;
    assign e     = e_q;
    assign l     = l_q;
    assign err   = err_q;
    assign count = count_q;

endmodule

// File: tb/tb_mag_comparator_serial.sv
// Scoreboard bench for mag_comparator_serial: WIDTH=4 and WIDTH=8 instances.
module tb_mag_comparator_serial;

    localparam logic [2:0] TG = 3'b100;
    localparam logic [2:0] TE = 3'b010;
    localparam logic [2:0] TL = 3'b001;

    typedef struct {
        logic g;
        logic e;
        logic l;
        logic err;
        int   count;
        int   at;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic bit_valid;
    logic [2:0] trip;
    logic sel;
    int cyc_cnt = 0;
    int tests = 0;
    int fails = 0;

    exp_t q4[$];
    exp_t q8[$];

    logic s4, v4, s8, v8;
    assign s4 = start & ~sel;
    assign v4 = bit_valid & ~sel;
    assign s8 = start & sel;
    assign v8 = bit_valid & sel;

    logic d4_busy, d4_done, d4_g, d4_e, d4_l, d4_err;
    logic [2:0] d4_count;
    logic d8_busy, d8_done, d8_g, d8_e, d8_l, d8_err;
    logic [3:0] d8_count;

    mag_comparator_serial #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst(rst), .start(s4), .bit_valid(v4),
        .g_in(trip[2]), .e_in(trip[1]), .l_in(trip[0]),
        .busy(d4_busy), .done(d4_done), .g(d4_g), .e(d4_e),
        .l(d4_l), .err(d4_err), .count(d4_count)
    );

    mag_comparator_serial #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(s8), .bit_valid(v8),
        .g_in(trip[2]), .e_in(trip[1]), .l_in(trip[0]),
        .busy(d8_busy), .done(d8_done), .g(d8_g), .e(d8_e),
        .l(d8_l), .err(d8_err), .count(d8_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic s, input logic v, input logic [2:0] t);
        start     = s;
        bit_valid = v;
        trip      = t;
        @(posedge clk);
        #1;
    endtask

    task automatic push4(input logic eg, input logic ee, input logic el,
                         input logic er, input int c, input int lat);
        exp_t x;
        x = '{g: eg, e: ee, l: el, err: er, count: c, at: cyc_cnt + lat};
        q4.push_back(x);
    endtask

    task automatic push8(input logic eg, input logic ee, input logic el,
                         input logic er, input int c, input int lat);
        exp_t x;
        x = '{g: eg, e: ee, l: el, err: er, count: c, at: cyc_cnt + lat};
        q8.push_back(x);
    endtask

    task automatic chk_reset4(input string nm);
        chk({nm, " busy"}, d4_busy, 0);
        chk({nm, " done"}, d4_done, 0);
        chk({nm, " g"}, d4_g, 0);
        chk({nm, " e"}, d4_e, 0);
        chk({nm, " l"}, d4_l, 0);
        chk({nm, " err"}, d4_err, 0);
        chk({nm, " count"}, d4_count, 0);
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (d4_done) begin
            if (q4.size() == 0) begin
                chk("w4 unexpected done", 1, 0);
            end else begin
                x = q4.pop_front();
                chk("w4 done cycle", cyc_cnt, x.at);
                chk("w4 g", d4_g, x.g);
                chk("w4 e", d4_e, x.e);
                chk("w4 l", d4_l, x.l);
                chk("w4 err", d4_err, x.err);
                chk("w4 count", d4_count, x.count);
                chk("w4 busy at done", d4_busy, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t x;
        if (d8_done) begin
            if (q8.size() == 0) begin
                chk("w8 unexpected done", 1, 0);
            end else begin
                x = q8.pop_front();
                chk("w8 done cycle", cyc_cnt, x.at);
                chk("w8 g", d8_g, x.g);
                chk("w8 e", d8_e, x.e);
                chk("w8 l", d8_l, x.l);
                chk("w8 err", d8_err, x.err);
                chk("w8 count", d8_count, x.count);
            end
        end
    end

    logic [2:0] t8 [8];
    int ec;

    initial begin
        t8 = '{TE, TE, TE, TL, TG, TE, TE, TE};
        rst = 1'b1;
        start = 1'b0;
        bit_valid = 1'b0;
        trip = 3'b000;
        sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset4("reset");
        chk("reset w8 busy", d8_busy, 0);
        chk("reset w8 count", d8_count, 0);
        rst = 1'b0;
        cyc(0, 1, TG);
        chk("idle ignores bit", d4_busy, 0);

        // x=1010 y=1001
        cyc(1, 0, 3'b000);
        chk("start busy", d4_busy, 1);
        chk("start e", d4_e, 1);
`ifdef MAG_CMP_EARLY_DONE_EN
        push4(1, 0, 0, 0, 3, 3);
`else
        push4(1, 0, 0, 0, 4, 4);
`endif
        cyc(0, 1, TE);
        chk("t1 count after 1", d4_count, 1);
        cyc(0, 1, TE);
        cyc(0, 1, TG);
        cyc(0, 1, TL);

        // back-to-back start, x=y=0110
        cyc(1, 0, 3'b000);
        push4(0, 1, 0, 0, 4, 4);
        repeat (4) cyc(0, 1, TE);
        cyc(0, 0, 3'b000);

        // x=0111 y=1000
        cyc(1, 0, 3'b000);
`ifdef MAG_CMP_EARLY_DONE_EN
        push4(0, 0, 1, 0, 1, 1);
`else
        push4(0, 0, 1, 0, 4, 4);
`endif
        cyc(0, 1, TL);
        cyc(0, 1, TG);
        cyc(0, 1, TG);
        cyc(0, 1, TG);
        repeat (2) cyc(0, 0, 3'b000);

        // non-one-hot second triple
        cyc(1, 0, 3'b000);
`ifdef MAG_CMP_EARLY_DONE_EN
        push4(1, 0, 0, 1, 3, 3);
`else
        push4(1, 0, 0, 1, 4, 4);
`endif
        cyc(0, 1, TE);
        cyc(0, 1, 3'b101);
        chk("err sticky", d4_err, 1);
        chk("err counted", d4_count, 2);
        chk("err keeps e", d4_e, 1);
        cyc(0, 1, TG);
        cyc(0, 1, TE);
        repeat (2) cyc(0, 0, 3'b000);
        cyc(1, 0, 3'b000);
        chk("start clears err", d4_err, 0);
        chk("start clears count", d4_count, 0);
        push4(0, 1, 0, 0, 4, 4);
        repeat (4) cyc(0, 1, TE);
        repeat (2) cyc(0, 0, 3'b000);

        // reset mid-compare
        cyc(1, 0, 3'b000);
        cyc(0, 1, TE);
        cyc(0, 1, TE);
        rst = 1'b1;
        cyc(0, 1, TG);
        chk_reset4("mid reset");
        rst = 1'b0;
        repeat (5) cyc(0, 1, TG);
        chk("post reset busy", d4_busy, 0);
        chk("post reset count", d4_count, 0);

        // restart in place of bit 3, with a same-cycle bit ignored
        cyc(1, 0, 3'b000);
        cyc(0, 1, TE);
        cyc(0, 1, TE);
        cyc(1, 1, TL);
        chk("restart count", d4_count, 0);
        chk("restart e", d4_e, 1);
        chk("restart l", d4_l, 0);
        chk("restart busy", d4_busy, 1);
        chk("restart no done", d4_done, 0);
`ifdef MAG_CMP_EARLY_DONE_EN
        push4(1, 0, 0, 0, 1, 1);
`else
        push4(1, 0, 0, 0, 4, 4);
`endif
        cyc(0, 1, TG);
        cyc(0, 1, TE);
        cyc(0, 1, TE);
        cyc(0, 1, TE);
        repeat (2) cyc(0, 0, 3'b000);

        // WIDTH=8, one valid bit every 3 cycles
        sel = 1'b1;
        cyc(1, 0, 3'b000);
`ifdef MAG_CMP_EARLY_DONE_EN
        push8(0, 0, 1, 0, 4, 10);
`else
        push8(0, 0, 1, 0, 8, 22);
`endif
        for (int i = 0; i < 8; i++) begin
            cyc(0, 1, t8[i]);
`ifdef MAG_CMP_EARLY_DONE_EN
            ec = (i < 4) ? i + 1 : 4;
`else
            ec = i + 1;
`endif
            chk("w8 count", d8_count, ec);
            if (i < 7) begin
                repeat (2) cyc(0, 0, TG);
                chk("w8 count stable", d8_count, ec);
            end
        end
        repeat (3) cyc(0, 0, 3'b000);
        sel = 1'b0;

        chk("w4 pending", q4.size(), 0);
        chk("w8 pending", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
